// File: rtl/auv_pkg.sv
// Shared types and constants for the AUV Wishbone SRAM bridge.
//   auv_sram_state_t : bridge FSM states
//   AUV_SRAM_WAIT_W  : width of the wait-state counter (holds 0..7)
package auv_pkg;

  localparam int unsigned AUV_SRAM_WAIT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    WREC,
    RESP
  } auv_sram_state_t;

endpackage

// File: rtl/auv_wb_sram.sv
// Pipelined Wishbone B4 slave driving an external asynchronous 16-bit SRAM.
// One request outstanding at a time; programmable read/write strobe widths,
// byte-lane enables, and out-of-range error reporting.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i/stb_i/cyc_i : Wishbone request inputs
//   wb_dat_o/ack_o/stall_o/err_o          : Wishbone response outputs
//   sram_adr, sram_dq_o, sram_dq_oe       : SRAM word address, write data, data drive enable
//   sram_dq_i                             : SRAM read data
//   sram_ce_n/oe_n/we_n/lb_n/ub_n         : SRAM active-low control strobes
module auv_wb_sram
  import auv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned SRAM_AW    = 18,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  input  logic [1:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic                  wb_err_o,
  output logic [SRAM_AW-1:0]    sram_adr,
  input  logic [15:0]           sram_dq_i,
  output logic [15:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  localparam int unsigned HI_LSB = SRAM_AW + 1;
  localparam int unsigned CW     = AUV_SRAM_WAIT_W;

  auv_sram_state_t state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            err_pend, err_pend_nxt;
  logic            accept;
  logic            capture;
  logic            out_of_range;

  logic            ce_nxt, oe_nxt, we_nxt, dq_oe_nxt;
  logic            ack_nxt, err_nxt;
  logic [1:0]      lane_nxt;

  // Byte address LSB carries no information for a 16-bit slave.
  logic unused_adr_lsb;
  assign unused_adr_lsb = wb_adr_i[0];

  // Any address bit above the SRAM word range flags an access fault.
  assign out_of_range = |(wb_adr_i >> HI_LSB);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      err_pend   <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_stall_o <= 1'b0;
      wb_dat_o   <= '0;
      sram_adr   <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      err_pend   <= err_pend_nxt;
      wb_ack_o   <= ack_nxt;
      wb_err_o   <= err_nxt;
      wb_stall_o <= (state_nxt != IDLE);
      sram_dq_oe <= dq_oe_nxt;
      sram_ce_n  <= ce_nxt;
      sram_oe_n  <= oe_nxt;
      sram_we_n  <= we_nxt;
      sram_lb_n  <= lane_nxt[0];
      sram_ub_n  <= lane_nxt[1];
      // Address and write data only move on accept, so never under an active strobe.
      if (accept) begin
        sram_adr  <= wb_adr_i[SRAM_AW:1];
        sram_dq_o <= wb_dat_i;
      end
      if (capture) begin
        wb_dat_o <= sram_dq_i;
      end
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    err_pend_nxt = err_pend;
    accept       = 1'b0;
    capture      = 1'b0;
    ce_nxt       = 1'b1;
    oe_nxt       = 1'b1;
    we_nxt       = 1'b1;
    dq_oe_nxt    = 1'b0;
    ack_nxt      = 1'b0;
    err_nxt      = 1'b0;
    lane_nxt     = {sram_ub_n, sram_lb_n};

    unique case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          accept = 1'b1;
          if (out_of_range) begin
            state_nxt    = RESP;
            err_pend_nxt = 1'b1;
          end else if (wb_we_i) begin
            state_nxt    = WRITE;
            cnt_nxt      = CW'(WR_WAIT);
            err_pend_nxt = 1'b0;
          end else begin
            state_nxt    = READ;
            cnt_nxt      = CW'(RD_WAIT);
            err_pend_nxt = 1'b0;
          end
        end
      end
      READ: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      WRITE: begin
        if (cnt == '0) begin
          state_nxt = WREC;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      WREC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Strobes follow the state being entered so they are registered.
    unique case (state_nxt)
      READ: begin
        ce_nxt = 1'b0;
        oe_nxt = 1'b0;
      end
      WRITE: begin
        ce_nxt    = 1'b0;
        we_nxt    = 1'b0;
        dq_oe_nxt = 1'b1;
      end
      WREC: begin
        ce_nxt    = 1'b0;
        dq_oe_nxt = 1'b1;
      end
      RESP: begin
        // A master that dropped cyc gets no response.
        ack_nxt = wb_cyc_i && !err_pend_nxt;
        err_nxt = wb_cyc_i &&  err_pend_nxt;
      end
      default: ;
    endcase

    // Lane enables are held for the whole access and released at response.
    if (accept && !out_of_range) begin
      lane_nxt = ~wb_sel_i;
    end else if ((state_nxt == RESP) || (state_nxt == IDLE)) begin
      lane_nxt = 2'b11;
    end
  end

endmodule

// File: tb/tb_auv_wb_sram.sv
// Scoreboard bench for auv_wb_sram: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever ack or err is presented.
module tb_auv_wb_sram;

  localparam int unsigned AW  = 24;
  localparam int unsigned SAW = 18;
  localparam int unsigned RDW = 1;
  localparam int unsigned WRW = 1;

  logic           clk;
  logic           rst;
  logic [AW-1:0]  wb_adr_i;
  logic [15:0]    wb_dat_i;
  logic [15:0]    wb_dat_o;
  logic [1:0]     wb_sel_i;
  logic           wb_we_i;
  logic           wb_stb_i;
  logic           wb_cyc_i;
  logic           wb_ack_o;
  logic           wb_stall_o;
  logic           wb_err_o;
  logic [SAW-1:0] sram_adr;
  logic [15:0]    sram_dq_i;
  logic [15:0]    sram_dq_o;
  logic           sram_dq_oe;
  logic           sram_ce_n;
  logic           sram_oe_n;
  logic           sram_we_n;
  logic           sram_lb_n;
  logic           sram_ub_n;

  auv_wb_sram #(
    .ADDR_WIDTH(AW), .SRAM_AW(SAW), .RD_WAIT(RDW), .WR_WAIT(WRW)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .wb_err_o(wb_err_o), .sram_adr(sram_adr), .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
    .sram_ub_n(sram_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model.
  logic [15:0] mem [0:(1<<SAW)-1];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 16'h0000;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_adr][7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_adr][15:8] = sram_dq_o[15:8];
    end
  end

  typedef struct {
    bit          is_err;
    bit          has_data;
    logic [15:0] data;
    int          lat;
    int          ce;
    int          oe;
    int          we;
    int          dq;
    logic [17:0] adr;
    logic [1:0]  lanes;   // {ub_n, lb_n}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_n    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: per-transaction strobe accounting and response comparison.
  int          acc_c = 0, ce_lo = 0, oe_lo = 0, we_lo = 0, dq_lo = 0;
  bit          overlap = 0, seen_ce = 0;
  logic [17:0] adr_seen = '0;
  logic [1:0]  lane_seen = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!sram_ce_n) begin
      ce_lo++;
      if (!seen_ce) begin
        seen_ce   = 1;
        adr_seen  = sram_adr;
        lane_seen = {sram_ub_n, sram_lb_n};
      end
    end
    if (!sram_oe_n) oe_lo++;
    if (!sram_we_n) we_lo++;
    if (sram_dq_oe) dq_lo++;
    if (!sram_oe_n && !sram_we_n) overlap = 1;

    if (wb_ack_o || wb_err_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, wb_ack_o, wb_err_o}, {30'd0, !e.is_err, e.is_err});
        check("latency", 32'(cyc_n - acc_c), 32'(e.lat));
        check("stall_in_resp", {31'd0, wb_stall_o}, 32'd1);
        check("ce_low_cycles", 32'(ce_lo), 32'(e.ce));
        check("oe_low_cycles", 32'(oe_lo), 32'(e.oe));
        check("we_low_cycles", 32'(we_lo), 32'(e.we));
        check("dq_oe_cycles", 32'(dq_lo), 32'(e.dq));
        check("oe_we_overlap", {31'd0, overlap}, 32'd0);
        if (!e.is_err) begin
          check("sram_adr", {14'd0, adr_seen}, {14'd0, e.adr});
          check("lanes", {30'd0, lane_seen}, {30'd0, e.lanes});
        end
        if (e.has_data) check("rdata", {16'd0, wb_dat_o}, {16'd0, e.data});
      end
    end

    // Request visible with stall low: the next edge accepts it.
    if (!rst && wb_cyc_i && wb_stb_i && !wb_stall_o) begin
      acc_c = cyc_n; ce_lo = 0; oe_lo = 0; we_lo = 0; dq_lo = 0;
      overlap = 0; seen_ce = 0;
    end
  end

  task automatic exp_read(input logic [17:0] w, input logic [15:0] d);
    exp_t x;
    x = '{is_err:0, has_data:1, data:d, lat:RDW+2, ce:RDW+1, oe:RDW+1,
          we:0, dq:0, adr:w, lanes:2'b00};
    exp_q.push_back(x);
  endtask

  task automatic exp_write(input logic [17:0] w, input logic [1:0] lanes);
    exp_t x;
    x = '{is_err:0, has_data:0, data:16'h0, lat:WRW+3, ce:WRW+2, oe:0,
          we:WRW+1, dq:WRW+2, adr:w, lanes:lanes};
    exp_q.push_back(x);
  endtask

  task automatic exp_err();
    exp_t x;
    x = '{is_err:1, has_data:0, data:16'h0, lat:1, ce:0, oe:0,
          we:0, dq:0, adr:18'h0, lanes:2'b11};
    exp_q.push_back(x);
  endtask

  // Present a request and hold stb until the accept edge; returns just after it.
  task automatic send(input logic [23:0] a, input logic [15:0] d,
                      input logic [1:0] s, input logic w);
    bit ok;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = w;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!wb_stall_o) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wb_stb_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("resp_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    wb_cyc_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    mem[18'h12] = 16'hBEEF;
    mem[18'h40] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_err", {31'd0, wb_err_o}, 32'd0);
    check("rst_stall", {31'd0, wb_stall_o}, 32'd0);
    check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_adr", {14'd0, sram_adr}, 32'd0);
    check("rst_dq_o", {16'd0, sram_dq_o}, 32'd0);
    check("rst_dat_o", {16'd0, wb_dat_o}, 32'd0);
    @(posedge clk); #1;

    // Plain read of word 0x12.
    exp_read(18'h12, 16'hBEEF);
    send(24'h000024, 16'h0000, 2'b11, 1'b0);
    wait_done();

    // Full-word write to word 0x80.
    exp_write(18'h80, 2'b00);
    send(24'h000100, 16'h1234, 2'b11, 1'b1);
    wait_done();
    check("mem_0x80", {16'd0, mem[18'h80]}, 32'h1234);

    // Upper-byte write onto a word holding 0xFFFF.
    exp_write(18'h40, 2'b01);
    send(24'h000080, 16'hAB55, 2'b10, 1'b1);
    wait_done();
    check("mem_0x40", {16'd0, mem[18'h40]}, 32'hABFF);

    // Out-of-range address: error, no SRAM activity.
    exp_err();
    send(24'h080000, 16'h0000, 2'b11, 1'b0);
    wait_done();
    check("dat_o_hold", {16'd0, wb_dat_o}, 32'hBEEF);

    // Back-to-back read then low-byte write, stb held across the stall.
    exp_read(18'h80, 16'h1234);
    exp_write(18'h12, 2'b10);
    send(24'h000100, 16'h0000, 2'b11, 1'b0);
    send(24'h000024, 16'hCAFE, 2'b01, 1'b1);
    wait_done();
    check("mem_0x12", {16'd0, mem[18'h12]}, 32'hBEFE);

    // Master drops cyc mid-write: write completes, no response.
    send(24'h000300, 16'h7777, 2'b11, 1'b1);
    wb_cyc_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("cyc_drop_mem", {16'd0, mem[18'h180]}, 32'h7777);
    check("cyc_drop_stall", {31'd0, wb_stall_o}, 32'd0);

    // Reset during the second WRITE cycle cuts the strobe.
    send(24'h000200, 16'h5555, 2'b11, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    @(negedge clk);
    check("post_rst_ctl", {28'd0, sram_we_n, sram_ce_n, sram_dq_oe, wb_ack_o}, 32'b1100);
    check("post_rst_stall", {31'd0, wb_stall_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wb_cyc_i = 1'b0;
    @(posedge clk); #1;

    exp_read(18'h12, 16'hBEFE);
    send(24'h000024, 16'h0000, 2'b11, 1'b0);
    wait_done();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/auv_wb_sram.md
Name: auv_wb_sram

Overview:
Pipelined Wishbone B4 slave that sits directly downstream of the core's 16-bit Wishbone master port and drives an external asynchronous 16-bit SRAM. It converts single requests into timed SRAM read/write cycles with programmable wait states and byte-lane enables. It reports out-of-range accesses with wb_err_o so the core raises load/store access faults.

Parameters:
ADDR_WIDTH, 24, Wishbone byte-address width; matches the core.
SRAM_AW, 18, SRAM word-address width, giving 2^SRAM_AW x 16-bit words.
RD_WAIT, 1, extra cycles the SRAM read strobe is held; legal range 0..7.
WR_WAIT, 1, extra cycles the SRAM write strobe is held; legal range 0..7.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wb_adr_i  in  ADDR_WIDTH  byte address; bit 0 is ignored
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_sel_i  in  2  byte-lane select; bit 1 is the upper byte
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  transfer acknowledge
wb_stall_o  out  1  request not accepted
wb_err_o  out  1  address error
sram_adr  out  SRAM_AW  SRAM word address
sram_dq_i  in  16  SRAM data in
sram_dq_o  out  16  SRAM data out
sram_dq_oe  out  1  tri-state enable for sram_dq_o
sram_ce_n  out  1  chip enable
sram_oe_n  out  1  output enable
sram_we_n  out  1  write enable
sram_lb_n  out  1  lower byte enable
sram_ub_n  out  1  upper byte enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the clk rising edge.
- Reset values: state IDLE; ack/err 0; stall 0; wb_dat_o 0; sram_ce_n/oe_n/we_n/lb_n/ub_n 1; sram_dq_oe 0; sram_adr 0; sram_dq_o 0.
- States: IDLE, READ, WRITE, WREC (write recovery), RESP.
- Stall and acceptance:
  - wb_stall_o = (state != IDLE). Only one request is outstanding at a time.
  - A request is accepted on an edge where state==IDLE and cyc&stb are high.
  - On acceptance, latch adr[SRAM_AW:1] into sram_adr, dat_i into sram_dq_o, and ~sel into lb_n/ub_n (both held through the access). Load wait counter cnt with RD_WAIT or WR_WAIT.
- Range check: if any of adr[ADDR_WIDTH-1:SRAM_AW+1] is nonzero, go IDLE->RESP with err pending; no SRAM strobe is asserted.
- IDLE->READ when !we:
  - ce_n=0, oe_n=0 for RD_WAIT+1 cycles; cnt decrements each cycle.
  - On the cnt==0 cycle, register sram_dq_i into wb_dat_o, then go to RESP.
- IDLE->WRITE when we:
  - ce_n=0, we_n=0, dq_oe=1 for WR_WAIT+1 cycles, then go to WREC.
  - WREC (1 cycle): we_n=1, ce_n=0, dq_oe=1 (data hold), then go to RESP.
- RESP (1 cycle): wb_ack_o=1, or wb_err_o=1 for a range error; all SRAM strobes inactive; next state IDLE.
- Latency from accept edge to ack visible:
  - read: RD_WAIT+2 cycles.
  - write: WR_WAIT+3 cycles.
  - error: 1 cycle.
- ack and err are never both high and each is high for exactly one cycle per accepted request.
- cyc dropped mid-access: the SRAM access runs to completion (no truncated write pulse). ack/err in RESP are gated by the cyc latched at RESP entry, so no ack is returned when cyc is low.
- sel==00 write: runs the full timing with lb_n=ub_n=1 (no byte written) and acks normally. sel==00 read returns the full word.
- wb_dat_o holds its last read value until the next read completes.
- Reset asserted in any state: next edge forces the reset values. A write in progress is cut and we_n returns to 1 on that edge.
- sram_adr and dq_o change only on accept edges, never while a strobe is active.

Decomposition:
- auv_pkg gains the state enum auv_sram_state_t {IDLE, READ, WRITE, WREC, RESP} and the constant AUV_SRAM_WAIT_W=3 (cnt width).
- Single module; no sub-module needed. The pad tri-state buffer lives at the chip top, outside this block.

Test Plan:
- Read, RD_WAIT=1: SRAM word 0x0012 holds 0xBEEF; WB read adr 0x000024 -> sram_adr=0x12, oe_n low 2 cycles, ack 3 cycles after accept with wb_dat_o=0xBEEF, stall high until IDLE.
- Write, WR_WAIT=1, sel=11: adr 0x000100, dat 0x1234 -> we_n low exactly 2 cycles, dq_oe=1 for 3 cycles, ack at cycle 4; memory model word 0x80 = 0x1234.
- Byte write sel=10, dat 0xAB55 onto word 0xFFFF -> ub_n=0, lb_n=1; word becomes 0xABFF.
- Out of range: adr 0x080000 with SRAM_AW=18 -> wb_err_o one cycle after accept, ack=0, ce_n stays 1.
- Back-to-back: read then write issued with stb held high -> second request is stalled until IDLE; exactly two acks in order; no overlap of oe_n and we_n low.
- rst asserted in the second WRITE cycle -> next edge we_n=1, ce_n=1, dq_oe=0, no ack; a following read completes normally.
